// File: rtl/counter_run_controller.sv
// Run/pause/done sequencer for a WIDTH-bit up-counter with programmable terminal
// count, one-shot or auto-reload operation, and a one-slot valid/ready command port.
module counter_run_controller #(
  parameter int WIDTH = 4,
  parameter int RLD_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic             cmd_mode,
  output logic [WIDTH-1:0] q,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done,
  output logic             tc_pulse,
  output logic [RLD_W-1:0] reloads
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_HOLD  = 2'b10;
  localparam logic [1:0] OP_ABORT = 2'b11;

  state_t           st, st_nxt;
  logic [WIDTH-1:0] lim, lim_nxt, q_nxt;
  logic             mode, mode_nxt;
  logic             tc_nxt;
  logic [RLD_W-1:0] rld_nxt;
  logic             accept;

  function automatic logic [RLD_W-1:0] sat_inc(input logic [RLD_W-1:0] v);
    return (&v) ? v : v + {{(RLD_W-1){1'b0}}, 1'b1};
  endfunction

  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= S_IDLE;
    else        st <= st_nxt;
  end

  // Accepted commands take precedence; a NOP falls through to normal counting.
  always_comb begin
    st_nxt   = st;
    q_nxt    = q;
    lim_nxt  = lim;
    mode_nxt = mode;
    tc_nxt   = 1'b0;
    rld_nxt  = reloads;
    if (accept && cmd_op == OP_START) begin
      lim_nxt  = cmd_limit;
      mode_nxt = cmd_mode;
      q_nxt    = '0;
      rld_nxt  = '0;
      st_nxt   = S_RUN;
    end else if (accept && cmd_op == OP_ABORT) begin
      st_nxt = S_IDLE;
      q_nxt  = '0;
    end else if (accept && cmd_op == OP_HOLD && st == S_RUN) begin
      st_nxt = S_PAUSE;
    end else if (accept && cmd_op == OP_HOLD && st == S_PAUSE) begin
      st_nxt = S_RUN;
    end else if (st == S_RUN) begin
      if (q != lim) begin
        q_nxt = q + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
        tc_nxt = 1'b1;
        if (mode) begin
          q_nxt   = '0;
          rld_nxt = sat_inc(reloads);
        end else begin
          st_nxt = S_DONE;
        end
      end
    end
  end

  always_comb begin
    busy  = (st == S_RUN) || (st == S_PAUSE);
    done  = (st == S_DONE);
    state = st;
  end

  // Registered datapath and handshake; ready drops for one cycle after each accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q         <= '0;
      lim       <= '0;
      mode      <= 1'b0;
      tc_pulse  <= 1'b0;
      reloads   <= '0;
      cmd_ready <= 1'b1;
    end else begin
      q         <= q_nxt;
      lim       <= lim_nxt;
      mode      <= mode_nxt;
      tc_pulse  <= tc_nxt;
      reloads   <= rld_nxt;
      cmd_ready <= !accept;
    end
  end

endmodule

// File: tb/tb_counter_run_controller.sv
// Bench for counter_run_controller: directed scenarios with literal checks, then
// random commands compared every cycle against a behavioural model.
module tb_counter_run_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_limit = 4'd0;
  logic       cmd_mode = 1'b0;
  logic [3:0] q;
  logic [1:0] state;
  logic       busy, done, tc_pulse;
  logic [7:0] reloads;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: state as 0 idle / 1 run / 2 pause / 3 done, everything else plain ints.
  int m_st = 0, m_q = 0, m_lim = 0, m_rel = 0;
  bit m_mode = 0, m_tc = 0, m_rdy = 1;

  counter_run_controller #(.WIDTH(4), .RLD_W(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_limit(cmd_limit), .cmd_mode(cmd_mode), .q(q),
    .state(state), .busy(busy), .done(done), .tc_pulse(tc_pulse), .reloads(reloads)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_q = 0; m_lim = 0; m_rel = 0; m_mode = 0; m_tc = 0; m_rdy = 1;
  endtask

  task automatic model_step();
    bit acc;
    int op;
    acc  = cmd_valid && m_rdy;
    op   = int'(cmd_op);
    m_tc = 0;
    m_rdy = !acc;
    if (acc && op == 1) begin
      m_lim = int'(cmd_limit); m_mode = cmd_mode; m_q = 0; m_rel = 0; m_st = 1;
    end else if (acc && op == 3) begin
      m_st = 0; m_q = 0;
    end else if (acc && op == 2 && (m_st == 1 || m_st == 2)) begin
      m_st = 3 - m_st;
    end else if (m_st == 1) begin
      if (m_q < m_lim) m_q = m_q + 1;
      else begin
        m_tc = 1;
        if (m_mode) begin
          m_q = 0;
          m_rel = (m_rel < 255) ? m_rel + 1 : 255;
        end else m_st = 3;
      end
    end
  endtask

  always begin
    @(posedge clk or negedge reset);
    if (!reset) model_reset();
    else        model_step();
    #1;
    chk("q", int'(q), m_q);
    chk("state", int'(state), m_st);
    chk("busy", int'(busy), int'(m_st == 1 || m_st == 2));
    chk("done", int'(done), int'(m_st == 3));
    chk("tc_pulse", int'(tc_pulse), int'(m_tc));
    chk("reloads", int'(reloads), m_rel);
    chk("cmd_ready", int'(cmd_ready), int'(m_rdy));
  end

  // Call at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic send(input logic [1:0] op, input logic [3:0] lim, input logic md);
    logic acc;
    acc = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_limit = lim; cmd_mode = md;
    for (int n = 0; n < 4 && !acc; n++) begin
      acc = cmd_ready;
      @(posedge clk);
      #1;
    end
    chk("handshake", int'(acc), 1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'b00;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cycles(3);
    chk("rst_q", int'(q), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_reloads", int'(reloads), 0);
    reset = 1'b1;
    cycles(1);

    // One-shot to 5
    send(2'b01, 4'd5, 1'b0);
    chk("os_q0", int'(q), 0);
    chk("os_ready_after_acc", int'(cmd_ready), 0);
    cycles(5);
    chk("os_q5", int'(q), 5);
    chk("os_tc_early", int'(tc_pulse), 0);
    cycles(1);
    chk("os_tc", int'(tc_pulse), 1);
    chk("os_done", int'(done), 1);
    cycles(1);
    chk("os_tc_once", int'(tc_pulse), 0);
    chk("os_q_hold", int'(q), 5);

    // Auto-reload limit 3, 12 cycles
    send(2'b01, 4'd3, 1'b1);
    cycles(12);
    chk("ar_reloads", int'(reloads), 3);
    chk("ar_tc", int'(tc_pulse), 1);
    chk("ar_busy", int'(busy), 1);

    // Pause and resume, limit 9
    send(2'b01, 4'd9, 1'b0);
    cycles(4);
    chk("ps_q4", int'(q), 4);
    send(2'b10, 4'd0, 1'b0);
    cycles(6);
    chk("ps_frozen", int'(q), 4);
    chk("ps_state", int'(state), 2);
    send(2'b10, 4'd0, 1'b0);
    cycles(5);
    chk("ps_q9", int'(q), 9);
    cycles(1);
    chk("ps_done", int'(done), 1);

    // Limit 0 auto-reload: saturating reload counter
    send(2'b01, 4'd0, 1'b1);
    cycles(300);
    chk("z_reloads_sat", int'(reloads), 255);
    chk("z_tc", int'(tc_pulse), 1);

    // Abort on the terminal edge
    send(2'b01, 4'd2, 1'b1);
    cycles(5);
    chk("ab_q2", int'(q), 2);
    chk("ab_rel1", int'(reloads), 1);
    send(2'b11, 4'd0, 1'b0);
    chk("ab_state", int'(state), 0);
    chk("ab_q", int'(q), 0);
    chk("ab_tc", int'(tc_pulse), 0);
    chk("ab_rel_kept", int'(reloads), 1);

    // Asynchronous reset mid-run
    send(2'b01, 4'd0, 1'b1);
    cycles(5);
    #2 reset = 1'b0;
    #1;
    chk("ar_rst_tc", int'(tc_pulse), 0);
    chk("ar_rst_rel", int'(reloads), 0);
    chk("ar_rst_state", int'(state), 0);
    cycles(2);
    reset = 1'b1;
    send(2'b01, 4'd1, 1'b0);
    cycles(1);
    chk("pr_q1", int'(q), 1);
    cycles(1);
    chk("pr_done", int'(done), 1);

    // Random commands against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_limit = 4'($urandom_range(0, 6));
      cmd_mode  = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cycles(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
